// File: rtl/updown_counter_param_pkg.sv
// Shared mode codes for the up/down counter family.
package updown_counter_param_pkg;
    localparam logic [1:0] CNT_MODE_WRAP    = 2'b00;
    localparam logic [1:0] CNT_MODE_MODULO  = 2'b01;
    localparam logic [1:0] CNT_MODE_ONESHOT = 2'b10;
endpackage

// File: rtl/counter_prescaler.sv
// Enable-tick divider: tick on every PRESCALE-th cycle with en=1.
module counter_prescaler #(
    parameter int PRESCALE = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);
    localparam logic [PW-1:0] ONE  = PW'(1);

    logic [PW-1:0] ph_q;
    logic [PW-1:0] ph_d;

    assign tick = en && (ph_q == LAST);

    always_comb begin
        ph_d = ph_q;
        if (clr)
            ph_d = '0;
        else if (en)
            ph_d = tick ? '0 : ph_q + ONE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ph_q <= '0;
        else
            ph_q <= ph_d;
    end
endmodule

// File: rtl/updown_counter_param.sv
// Up/down counter with load, WRAP/MODULO/ONESHOT modes and registered Rc/done.
// Optional enable prescaler selected by the CNT_PRESCALE_EN macro.
module updown_counter_param
    import updown_counter_param_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int PRESCALE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             s,
    input  logic             Load,
    input  logic [WIDTH-1:0] PData,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] cnt,
    output logic             Rc,
    output logic             done
);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             rc_q, rc_d;
    logic             done_q, done_d;
    logic             tick;
    logic             bounded;
    logic             step;
    logic [WIDTH-1:0] term;
    logic [WIDTH-1:0] mod_next;

`ifdef CNT_PRESCALE_EN
    counter_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_presc (
        .clk  (clk),
        .rst  (rst),
        .clr  (Load),
        .en   (en),
        .tick (tick)
    );
`else
    assign tick = (PRESCALE >= 1);
`endif

    assign bounded = (mode == CNT_MODE_MODULO) || (mode == CNT_MODE_ONESHOT);
    assign term    = s ? (bounded ? limit : '1) : '0;
    assign step    = en && tick && !done_q;

    always_comb begin
        mod_next = '0;
        if (s)
            mod_next = (cnt_q >= limit) ? '0 : cnt_q + ONE;
        else
            mod_next = (cnt_q == '0) ? limit : cnt_q - ONE;
    end

    always_comb begin
        cnt_d  = cnt_q;
        done_d = done_q;
        rc_d   = 1'b0;
        if (Load) begin
            cnt_d  = PData;
            done_d = 1'b0;
        end else if (step) begin
            unique case (mode)
                CNT_MODE_MODULO:
                    cnt_d = mod_next;
                CNT_MODE_ONESHOT:
                    // Up with cnt above limit is treated as already terminal
                    if ((cnt_q == term) || (s && (cnt_q > limit)))
                        done_d = 1'b1;
                    else
                        cnt_d = mod_next;
                default:
                    cnt_d = s ? cnt_q + ONE : cnt_q - ONE;
            endcase
            rc_d = (cnt_d == term) && (cnt_q != term);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            rc_q   <= 1'b0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            rc_q   <= rc_d;
            done_q <= done_d;
        end
    end

    assign cnt  = cnt_q;
    assign Rc   = rc_q;
    assign done = done_q;
endmodule
